alu_sequencer: RTL and testbench

//  Fetch/execute control FSM for the 16-bit CPU datapath. Fetches instructions into IR',

---
 rtl/alu_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Fetch/execute control FSM for the 16-bit CPU: instruction fetch into IR',
// exec1/exec2 timing strobes, and the CARRY/SKIP status flip-flops.
module alu_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ready,
   input  logic              halt_req,
   input  logic              carryout,
   input  logic              carryen,
   input  logic              skipout,
   input  logic              skipen,
   output logic [ADDR_W-1:0] pc,
   output logic              mem_rd,
   output logic [15:0]       ir,
   output logic              exec1,
   output logic              exec2,
   output logic              carry_q,
   output logic              skip_q,
   output logic              halted
);

   localparam int unsigned IR_W = 16;

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC1 = 2'd1;
   localparam logic [1:0] S_EXEC2 = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   // Opcode classes taken from the top two IR bits
   localparam logic [1:0] OP_JMP = 2'b10;
   localparam logic [1:0] OP_ALU = 2'b11;

   logic [1:0]        state;
   logic [1:0]        state_d;
   logic [ADDR_W-1:0] pc_d;
   logic [IR_W-1:0]   ir_d;
   logic              carry_d;
   logic              skip_d;
   logic              mem_rd_d;
   logic              exec1_d;
   logic              exec2_d;
   logic              halted_d;

   // Next-state, datapath and strobe decode; strobes are decoded from the
   // next state so they appear registered yet track the current state exactly.
   always_comb begin
      state_d = state;
      pc_d    = pc;
      ir_d    = ir;
      carry_d = carry_q;
      skip_d  = skip_q;

      case (state)
         S_FETCH: begin
            if (mem_ready) begin
               pc_d = pc + ADDR_W'(1);
               if (skip_q) begin
                  // Skipped word is dropped; fetch continues at the next address
                  skip_d = 1'b0;
               end else begin
                  ir_d    = mem_rdata;
                  state_d = S_EXEC1;
               end
            end
         end
         S_EXEC1: begin
            if (carryen) carry_d = carryout;
            if (skipen)  skip_d  = skipout;
            if (ir[15:14] == OP_ALU) begin
               state_d = halt_req ? S_HALT : S_FETCH;
            end else begin
               state_d = S_EXEC2;
            end
         end
         S_EXEC2: begin
            // Jump target overrides the already-incremented fetch address
            if (ir[15:14] == OP_JMP) pc_d = ir[ADDR_W-1:0];
            state_d = halt_req ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            if (!halt_req) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      mem_rd_d = (state_d == S_FETCH);
      exec1_d  = (state_d == S_EXEC1);
      exec2_d  = (state_d == S_EXEC2);
      halted_d = (state_d == S_HALT);
   end

   // State, architectural registers and strobe registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_FETCH;
         pc      <= ADDR_W'(RESET_PC);
         ir      <= '0;
         carry_q <= 1'b0;
         skip_q  <= 1'b0;
         mem_rd  <= 1'b1;
         exec1   <= 1'b0;
         exec2   <= 1'b0;
         halted  <= 1'b0;
      end else begin
         state   <= state_d;
         pc      <= pc_d;
         ir      <= ir_d;
         carry_q <= carry_d;
         skip_q  <= skip_d;
         mem_rd  <= mem_rd_d;
         exec1   <= exec1_d;
         exec2   <= exec2_d;
         halted  <= halted_d;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios followed by
// randomized traffic, all compared against an instruction-level model.
module tb_alu_sequencer;

   logic        clk;
   logic        reset;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        halt_req;
   logic        carryout;
   logic        carryen;
   logic        skipout;
   logic        skipen;
   logic [7:0]  pc;
   logic        mem_rd;
   logic [15:0] ir;
   logic        exec1;
   logic        exec2;
   logic        carry_q;
   logic        skip_q;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   alu_sequencer #(.ADDR_W(8), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .halt_req(halt_req), .carryout(carryout), .carryen(carryen),
      .skipout(skipout), .skipen(skipen), .pc(pc), .mem_rd(mem_rd), .ir(ir),
      .exec1(exec1), .exec2(exec2), .carry_q(carry_q), .skip_q(skip_q),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: instruction-level view (cycles left in current instruction)
   logic [7:0]  m_pc;
   logic [15:0] m_ir;
   logic        m_carry;
   logic        m_skip;
   logic        m_halt;
   int          m_left;

   function automatic int ilen(input logic [15:0] w);
      return (w[15:14] == 2'b11) ? 1 : 2;
   endfunction

   task automatic model_reset();
      m_pc = 8'h00; m_ir = 16'h0000; m_carry = 1'b0; m_skip = 1'b0;
      m_halt = 1'b0; m_left = 0;
   endtask

   task automatic model_step();
      int pos;
      if (m_halt) begin
         if (!halt_req) m_halt = 1'b0;
      end else if (m_left == 0) begin
         if (mem_ready) begin
            m_pc = m_pc + 8'd1;
            if (m_skip) m_skip = 1'b0;
            else begin
               m_ir   = mem_rdata;
               m_left = ilen(mem_rdata);
            end
         end
      end else begin
         pos = ilen(m_ir) - m_left + 1;
         if (pos == 1) begin
            if (carryen) m_carry = carryout;
            if (skipen)  m_skip  = skipout;
         end
         if (pos == 2 && m_ir[15:14] == 2'b10) m_pc = m_ir[7:0];
         m_left = m_left - 1;
         if (m_left == 0 && halt_req) m_halt = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string where);
      check({where, ".pc"},      {8'h00, pc}, {8'h00, m_pc});
      check({where, ".ir"},      ir, m_ir);
      check({where, ".carry_q"}, 16'(carry_q), 16'(m_carry));
      check({where, ".skip_q"},  16'(skip_q), 16'(m_skip));
      check({where, ".mem_rd"},  16'(mem_rd), 16'(!m_halt && m_left == 0));
      check({where, ".exec1"},   16'(exec1), 16'(!m_halt && m_left != 0 && m_left == ilen(m_ir)));
      check({where, ".exec2"},   16'(exec2), 16'(!m_halt && m_left == 1 && ilen(m_ir) == 2));
      check({where, ".halted"},  16'(halted), 16'(m_halt));
   endtask

   // One clock: drive inputs, advance model at the edge, compare just after
   task automatic step(input logic rdy, input logic [15:0] rd, input logic hr,
                       input logic co, input logic ce, input logic so, input logic se);
      mem_ready = rdy; mem_rdata = rd; halt_req = hr;
      carryout = co; carryen = ce; skipout = so; skipen = se;
      @(posedge clk);
      model_step();
      #1;
      check_all("cyc");
   endtask

   initial begin
      reset = 1'b1; mem_rdata = '0; mem_ready = 1'b0; halt_req = 1'b0;
      carryout = 1'b0; carryen = 1'b0; skipout = 1'b0; skipen = 1'b0;
      model_reset();
      #3;
      check_all("reset");
      @(posedge clk); #2 reset = 1'b0;

      // 1: ALU stream, single-cycle execute
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      check("t1_pc1", {8'h00, pc}, 16'h0001);
      check("t1_exec1", 16'(exec1), 16'h0001);
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      check("t1_pc2", {8'h00, pc}, 16'h0002);

      // 2: carry write then hold
      step(1, 16'hC000, 0, 1, 1, 0, 0);
      check("t2_carry", 16'(carry_q), 16'h0001);
      check("t2_skip", 16'(skip_q), 16'h0000);
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      check("t2_hold", 16'(carry_q), 16'h0001);

      // 3: skip discards the word at pc=4
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      check("t3_pc4", {8'h00, pc}, 16'h0004);
      step(1, 16'hC000, 0, 0, 0, 1, 1);
      step(1, 16'hC111, 0, 0, 0, 0, 0);
      check("t3_ir_kept", ir, 16'hC000);
      check("t3_no_exec", 16'(exec1), 16'h0000);
      step(1, 16'hC222, 0, 0, 0, 0, 0);
      check("t3_ir_new", ir, 16'hC222);

      // 4: jump
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      step(1, 16'h8025, 0, 0, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 0, 0);
      check("t4_exec2", 16'(exec2), 16'h0001);
      step(1, 16'h0000, 0, 0, 0, 0, 0);
      check("t4_pc", {8'h00, pc}, 16'h0025);

      // 5: wrap at 0xFF and fetch stall
      step(1, 16'h80FF, 0, 0, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 0, 0);
      check("t5_pcff", {8'h00, pc}, 16'h00FF);
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      check("t5_wrap", {8'h00, pc}, 16'h0000);
      step(0, 16'h0000, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 16'hFFFF, 0, 0, 0, 0, 0);
      check("t5_stall_pc", {8'h00, pc}, 16'h0000);

      // 6: halt at boundary, resume, reset during EXEC2
      step(1, 16'hC000, 0, 0, 0, 0, 0);
      step(1, 16'h1234, 1, 0, 0, 0, 0);
      check("t6_halted", 16'(halted), 16'h0001);
      step(1, 16'h5555, 1, 1, 1, 1, 1);
      check("t6_frozen", {8'h00, pc}, 16'h0001);
      step(1, 16'h5555, 0, 0, 0, 0, 0);
      step(1, 16'h4000, 0, 0, 0, 0, 0);
      step(1, 16'h0000, 1, 0, 0, 0, 0);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all("t6_reset");
      check("t6_carry0", 16'(carry_q), 16'h0000);
      @(posedge clk); #2 reset = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step(logic'($urandom_range(0, 3) != 0), 16'($urandom),
              logic'($urandom_range(0, 7) == 0),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
